// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  // Bits needed to count 0..limit, clamped to the 2..8 bit range.
  function automatic int starve_width(input int limit);
    int w;
    w = 1;
    while ((1 << w) <= limit) w++;
    if (w < 2) w = 2;
    if (w > 8) w = 8;
    return w;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// rtl/mem_arbiter_pick.sv - winner selection between fetch and data requesters
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  logic   starve_hit,
  output logic   grant,
  output owner_t owner
);

  // Data wins by default; fetch wins when alone or when it has waited long enough.
  always_comb begin
    grant = i_req | d_req;
    owner = OWN_D;
    if (i_req && (!d_req || starve_hit)) begin
      owner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-latency arbiter sharing one memory port between fetch and load/store
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_adress,
  output logic        i_ack,
  output logic [31:0] i_read_data,
  input  logic        d_req,
  input  logic        d_write_enable,
  input  logic [31:0] d_adress,
  input  logic [31:0] d_write_data,
  output logic        d_ack,
  output logic [31:0] d_read_data,
  output logic        d_misaligned,
  output logic        mem_write_enable,
  output logic [31:0] mem_adress,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int SW = starve_width(STARVE_LIMIT);
  localparam int LW = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY);
  localparam logic [LW-1:0] LAT_LOAD   = LW'(MEM_LATENCY - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t          state;
  owner_t          owner;
  logic [LW-1:0]   lat_cnt;
  logic [SW-1:0]   starve_cnt;
  logic            starve_hit;
  logic            grant;
  owner_t          grant_owner;
  logic            d_unaligned;

  assign starve_hit  = (starve_cnt == STARVE_MAX);
  assign d_unaligned = |d_adress[1:0];

  mem_arbiter_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .starve_hit (starve_hit),
    .grant      (grant),
    .owner      (grant_owner)
  );

  // Access sequencer: arbitrate in IDLE, hold the address for the latency window, ack in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      owner            <= OWN_I;
      lat_cnt          <= '0;
      starve_cnt       <= '0;
      i_ack            <= 1'b0;
      d_ack            <= 1'b0;
      d_misaligned     <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_adress       <= '0;
      mem_write_data   <= '0;
      i_read_data      <= '0;
      d_read_data      <= '0;
    end else begin
      case (state)
        IDLE: begin
          i_ack            <= 1'b0;
          d_ack            <= 1'b0;
          d_misaligned     <= 1'b0;
          mem_write_enable <= 1'b0;
          // Starvation only accumulates while fetch is actually waiting.
          if (!i_req || (grant && grant_owner == OWN_I)) begin
            starve_cnt <= '0;
          end else if (grant && !starve_hit) begin
            starve_cnt <= starve_cnt + SW'(1);
          end
          if (grant) begin
            owner <= grant_owner;
            if (grant_owner == OWN_D && d_unaligned) begin
              // Rejected without touching the memory registers.
              state        <= DONE;
              d_ack        <= 1'b1;
              d_misaligned <= 1'b1;
            end else begin
              state   <= ACCESS;
              lat_cnt <= LAT_LOAD;
              if (grant_owner == OWN_I) begin
                mem_adress       <= i_adress & WORD_ALIGN_MASK;
                mem_write_enable <= 1'b0;
              end else begin
                mem_adress       <= d_adress & WORD_ALIGN_MASK;
                mem_write_data   <= d_write_data;
                mem_write_enable <= d_write_enable;
              end
            end
          end
        end
        ACCESS: begin
          // The store strobe lasts only for the first access cycle.
          mem_write_enable <= 1'b0;
          if (lat_cnt == '0) begin
            state <= DONE;
            if (owner == OWN_I) begin
              i_read_data <= mem_read_data;
              i_ack       <= 1'b1;
            end else begin
              d_read_data <= mem_read_data;
              d_ack       <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        DONE: begin
          i_ack        <= 1'b0;
          d_ack        <= 1'b0;
          d_misaligned <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk;
  logic        reset, reset3;

  logic        i_req, d_req, d_we;
  logic [31:0] i_adr, d_adr, d_wd;
  logic        i_ack, d_ack, d_mis, mem_we;
  logic [31:0] i_rd, d_rd, mem_adr, mem_wd, mem_rd;

  logic        i_req3, d_req3;
  logic [31:0] i_adr3, d_adr3;
  logic        i_ack3, d_ack3, d_mis3, mem_we3;
  logic [31:0] i_rd3, d_rd3, mem_adr3, mem_wd3, mem_rd3;

  int passed = 0;
  int total  = 0;
  int we_count = 0;

  typedef struct {
    bit          is_d;
    bit          chk_data;
    bit          mis;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem1 [0:255];
  logic [255:0] wr1;

  mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_adress(i_adr), .i_ack(i_ack), .i_read_data(i_rd),
    .d_req(d_req), .d_write_enable(d_we), .d_adress(d_adr), .d_write_data(d_wd),
    .d_ack(d_ack), .d_read_data(d_rd), .d_misaligned(d_mis),
    .mem_write_enable(mem_we), .mem_adress(mem_adr), .mem_write_data(mem_wd),
    .mem_read_data(mem_rd)
  );

  mem_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clk(clk), .reset(reset3),
    .i_req(i_req3), .i_adress(i_adr3), .i_ack(i_ack3), .i_read_data(i_rd3),
    .d_req(d_req3), .d_write_enable(1'b0), .d_adress(d_adr3), .d_write_data(32'h0),
    .d_ack(d_ack3), .d_read_data(d_rd3), .d_misaligned(d_mis3),
    .mem_write_enable(mem_we3), .mem_adress(mem_adr3), .mem_write_data(mem_wd3),
    .mem_read_data(mem_rd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten words read back a fixed per-index pattern.
  function automatic logic [31:0] dflt(input logic [7:0] idx);
    if (idx == 8'd2) return 32'hE3A0_1005;
    return 32'h1000_0000 + {24'h0, idx} * 32'h0001_0011;
  endfunction

  assign mem_rd  = wr1[mem_adr[9:2]] ? mem1[mem_adr[9:2]] : dflt(mem_adr[9:2]);
  assign mem_rd3 = dflt(mem_adr3[9:2]);

  always @(posedge clk) begin
    if (mem_we) begin
      mem1[mem_adr[9:2]] <= mem_wd;
      wr1[mem_adr[9:2]]  <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input bit is_d, input bit chk, input bit mis, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d; e.chk_data = chk; e.mis = mis; e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input int sel, input string tag);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 40) begin
      @(posedge clk); #1;
      n++;
      case (sel)
        0: hit = i_ack;
        1: hit = d_ack;
        2: hit = i_ack3;
        default: hit = d_ack3;
      endcase
    end
    check(tag, {31'b0, hit}, 32'd1);
  endtask

  // Scoreboard monitor for the latency-1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (mem_we) we_count++;
    if (i_ack && d_ack) check("dual_ack", 32'd1, 32'd0);
    if (i_ack || d_ack) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_ack", {31'b0, i_ack | d_ack}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_owner", {31'b0, d_ack}, {31'b0, e.is_d});
        if (e.chk_data) check("sb_data", d_ack ? d_rd : i_rd, e.data);
        if (e.is_d) check("sb_misaligned", {31'b0, d_mis}, {31'b0, e.mis});
      end
    end
  end

  initial begin
    int acks;
    int n;
    reset = 1'b1; reset3 = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; i_adr = 0; d_adr = 0; d_wd = 0;
    i_req3 = 0; d_req3 = 0; i_adr3 = 0; d_adr3 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_i_ack", {31'b0, i_ack}, 0);
    check("rst_d_ack", {31'b0, d_ack}, 0);
    check("rst_d_mis", {31'b0, d_mis}, 0);
    check("rst_mem_we", {31'b0, mem_we}, 0);
    check("rst_mem_adr", mem_adr, 0);
    check("rst_mem_wd", mem_wd, 0);
    check("rst_i_rd", i_rd, 0);
    check("rst_d_rd", d_rd, 0);
    reset = 1'b0; reset3 = 1'b0;
    @(posedge clk); #1;

    // Single fetch at 0x8, latency 1: ack in cycle 2.
    we_count = 0;
    i_adr = 32'h8; i_req = 1;
    push(0, 1, 0, 32'hE3A0_1005);
    @(posedge clk); #1;
    check("f_c1_ack", {31'b0, i_ack}, 0);
    check("f_c1_adr", mem_adr, 32'h8);
    @(posedge clk); #1;
    check("f_c2_ack", {31'b0, i_ack}, 1);
    check("f_c2_data", i_rd, 32'hE3A0_1005);
    i_req = 0;
    @(posedge clk); #1;
    check("f_no_write", we_count, 0);

    // Store 0xDEADBEEF to 0x40, then load it back.
    we_count = 0;
    d_adr = 32'h40; d_wd = 32'hDEAD_BEEF; d_we = 1; d_req = 1;
    push(1, 0, 0, 32'h0);
    @(posedge clk); #1;
    check("st_c1_we", {31'b0, mem_we}, 1);
    check("st_c1_adr", mem_adr, 32'h40);
    @(posedge clk); #1;
    check("st_c2_ack", {31'b0, d_ack}, 1);
    check("st_commit", mem1[16], 32'hDEAD_BEEF);
    d_req = 0; d_we = 0;
    @(posedge clk); #1;
    check("st_we_once", we_count, 1);
    d_req = 1;
    push(1, 1, 0, 32'hDEAD_BEEF);
    wait_ack(1, "ld_ack");
    d_req = 0;
    @(posedge clk); #1;

    // Both requesters held: D,D,D,D,I repeating.
    i_adr = 32'h100; d_adr = 32'h200; d_we = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) push(0, 1, 0, dflt(8'd64));
      else push(1, 1, 0, dflt(8'd128));
    end
    i_req = 1; d_req = 1;
    acks = 0; n = 0;
    while (acks < 10 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (i_ack || d_ack) begin
        acks++;
        if (acks == 10) begin
          i_req = 0; d_req = 0;
        end
      end
    end
    i_req = 0; d_req = 0;
    check("starve_acks", acks, 10);
    @(posedge clk); #1;

    // Misaligned load at 0x42: immediate ack with error, memory untouched.
    we_count = 0;
    d_adr = 32'h42; d_we = 0; d_req = 1;
    push(1, 0, 1, 32'h0);
    @(posedge clk); #1;
    check("mis_c1_ack", {31'b0, d_ack}, 1);
    check("mis_c1_flag", {31'b0, d_mis}, 1);
    check("mis_c1_adr", mem_adr, 32'h100);
    d_req = 0;
    @(posedge clk); #1;
    check("mis_c2_ack", {31'b0, d_ack}, 0);
    check("mis_c2_adr", mem_adr, 32'h100);
    check("mis_no_write", we_count, 0);

    // Latency-3 fetch at 0xC: address held three cycles, ack in cycle 4.
    i_adr3 = 32'hC; i_req3 = 1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      check("l3_wait_ack", {31'b0, i_ack3}, 0);
      check("l3_adr_hold", mem_adr3, 32'hC);
    end
    @(posedge clk); #1;
    check("l3_ack", {31'b0, i_ack3}, 1);
    check("l3_data", i_rd3, dflt(8'd3));
    i_req3 = 0;
    @(posedge clk); #1;

    // Reset during ACCESS cycle 2 of a load, then re-issue.
    d_adr3 = 32'h10; d_req3 = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rs_c2_ack", {31'b0, d_ack3}, 0);
    reset3 = 1'b1;
    @(posedge clk); #1;
    check("rs_d_ack", {31'b0, d_ack3}, 0);
    check("rs_i_ack", {31'b0, i_ack3}, 0);
    check("rs_mem_adr", mem_adr3, 0);
    check("rs_mem_we", {31'b0, mem_we3}, 0);
    check("rs_i_rd", i_rd3, 0);
    check("rs_d_rd", d_rd3, 0);
    check("rs_d_mis", {31'b0, d_mis3}, 0);
    reset3 = 1'b0;
    wait_ack(3, "rs_reissue_ack");
    check("rs_reissue_data", d_rd3, dflt(8'd4));
    d_req3 = 0;
    repeat (2) @(posedge clk);
    #1;

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
